// File: rtl/rcon_gen.sv
// AES round-constant generator: produces Rcon[1..N] by GF(2^8) doubling (forward)
// or halving (reverse), stepped one constant per next pulse.
module rcon_gen #(
   parameter int OUT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       mode,
   input  logic             dir,
   input  logic             next,
   output logic [OUT_W-1:0] dout,
   output logic             valid,
   output logic [3:0]       idx,
   output logic             last,
   output logic             busy
);

   localparam logic [0:0] IDLE   = 1'b0;
   localparam logic [0:0] ACTIVE = 1'b1;

   logic [0:0]       state_q, state_d;
   logic [7:0]       rc_q, rc_d;
   logic [3:0]       idx_q, idx_d;
   logic             last_q, last_d;
   logic [1:0]       mode_q, mode_d;
   logic             dir_q, dir_d;
   logic             valid_q, valid_d;
   logic [OUT_W-1:0] dout_q, dout_d;

   // Number of round constants consumed by each key size; 11 falls back to AES-128.
   function automatic logic [3:0] seq_len(input logic [1:0] m);
      case (m)
         2'b01:   seq_len = 4'd8;
         2'b10:   seq_len = 4'd7;
         default: seq_len = 4'd10;
      endcase
   endfunction

   function automatic logic [7:0] rc_final(input logic [1:0] m);
      case (m)
         2'b01:   rc_final = 8'h80;
         2'b10:   rc_final = 8'h40;
         default: rc_final = 8'h36;
      endcase
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
   endfunction

   // Inverse of xtime: undo the reduction before shifting right.
   function automatic logic [7:0] inv_xtime(input logic [7:0] b);
      logic [7:0] t;
      t = b ^ 8'h1B;
      inv_xtime = b[0] ? {1'b1, t[7:1]} : {1'b0, b[7:1]};
   endfunction

   always_comb begin
      state_d = state_q;
      rc_d    = rc_q;
      idx_d   = idx_q;
      mode_d  = mode_q;
      dir_d   = dir_q;
      valid_d = valid_q;
      last_d  = last_q;

      if (start) begin
         state_d = ACTIVE;
         valid_d = 1'b1;
         mode_d  = mode;
         dir_d   = dir;
         if (dir) begin
            rc_d  = rc_final(mode);
            idx_d = seq_len(mode);
         end else begin
            rc_d  = 8'h01;
            idx_d = 4'd1;
         end
         last_d = dir_d ? (idx_d == 4'd1) : (idx_d == seq_len(mode_d));
      end else if (state_q == ACTIVE && next) begin
         if (last_q) begin
            state_d = IDLE;
            valid_d = 1'b0;
            last_d  = 1'b0;
         end else begin
            if (dir_q) begin
               rc_d  = inv_xtime(rc_q);
               idx_d = idx_q - 4'd1;
            end else begin
               rc_d  = xtime(rc_q);
               idx_d = idx_q + 4'd1;
            end
            last_d = dir_q ? (idx_d == 4'd1) : (idx_d == seq_len(mode_q));
         end
      end
   end

   always_comb begin
      dout_d = '0;
      dout_d[OUT_W-1 -: 8] = rc_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         rc_q    <= 8'h00;
         idx_q   <= 4'd0;
         last_q  <= 1'b0;
         mode_q  <= 2'b00;
         dir_q   <= 1'b0;
         valid_q <= 1'b0;
         dout_q  <= '0;
      end else begin
         state_q <= state_d;
         rc_q    <= rc_d;
         idx_q   <= idx_d;
         last_q  <= last_d;
         mode_q  <= mode_d;
         dir_q   <= dir_d;
         valid_q <= valid_d;
         dout_q  <= dout_d;
      end
   end

   assign dout  = dout_q;
   assign valid = valid_q;
   assign busy  = valid_q;
   assign idx   = idx_q;
   assign last  = last_q;

endmodule
